// File: rtl/edge_pkg.sv
// edge_pkg: shared down-counter FSM state type and reset state for the edge-detector datapath
package edge_pkg;
  typedef enum logic [1:0] {FDC_IDLE, FDC_RUN, FDC_EXPIRED} fdc_state_t;
  localparam fdc_state_t FDC_RESET_STATE = FDC_IDLE;
endpackage

// File: rtl/fdc_next_count.sv
// fdc_next_count: combinational next count, terminal and underflow detection for flex_down_counter
// Ports: count/reload in; next_count, terminal out; underflow out only with FLEX_DOWN_COUNTER_UNDERFLOW_EN
module fdc_next_count
  import edge_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int DECREMENT = 1,
  parameter bit AUTO_RELOAD = 0
) (
  input  logic [NUM_CNT_BITS-1:0] count,
  input  logic [NUM_CNT_BITS-1:0] reload,
  output logic [NUM_CNT_BITS-1:0] next_count,
  output logic                    terminal
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  ,
  output logic                    underflow
`endif
);
  localparam logic [NUM_CNT_BITS-1:0] STEP = NUM_CNT_BITS'(DECREMENT);
  // A step that would reach or pass zero is the terminal event; it saturates instead of wrapping
  always_comb begin
    terminal = count <= STEP;
    next_count = terminal ? (AUTO_RELOAD ? reload : '0) : count - STEP;
  end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  always_comb underflow = count < STEP;
`endif
endmodule

// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable programmable-step down-counter with terminal count and optional auto-reload
// Ports: clk, rst (async, active-high), clear, load, load_val, count_enable in;
// count_out, zero_flag, busy out; underflow_err out only with FLEX_DOWN_COUNTER_UNDERFLOW_EN
module flex_down_counter
  import edge_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int DECREMENT = 1,
  parameter bit AUTO_RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    busy
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  ,
  output logic                    underflow_err
`endif
);
  fdc_state_t state;
  logic [NUM_CNT_BITS-1:0] reload;
  logic [NUM_CNT_BITS-1:0] next_count;
  logic terminal;
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  logic underflow;
`endif
  fdc_next_count #(
    .NUM_CNT_BITS(NUM_CNT_BITS),
    .DECREMENT(DECREMENT),
    .AUTO_RELOAD(AUTO_RELOAD)
  ) u_next (
    .count(count_out),
    .reload(reload),
    .next_count(next_count),
    .terminal(terminal)
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    ,
    .underflow(underflow)
`endif
  );
  // IDLE and EXPIRED simply hold: count is already 0 and zero_flag keeps its state-specific value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FDC_RESET_STATE;
      count_out <= '0;
      reload <= '0;
      zero_flag <= 1'b0;
      busy <= 1'b0;
    end else if (clear) begin
      state <= FDC_IDLE;
      count_out <= '0;
      reload <= '0;
      zero_flag <= 1'b0;
      busy <= 1'b0;
    end else if (load) begin
      state <= (load_val != '0) ? FDC_RUN : FDC_EXPIRED;
      count_out <= load_val;
      reload <= load_val;
      zero_flag <= load_val == '0;
      busy <= load_val != '0;
    end else if (state == FDC_RUN) begin
      zero_flag <= count_enable && terminal;
      if (count_enable) begin
        count_out <= next_count;
        if (terminal && !AUTO_RELOAD) begin
          state <= FDC_EXPIRED;
          busy <= 1'b0;
        end
      end
    end
  end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  // Sticky until rst; clear and load deliberately leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underflow_err <= 1'b0;
    else if (!clear && !load && state == FDC_RUN && count_enable && underflow) underflow_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed self-checking bench for flex_down_counter in three configurations
module tb_flex_down_counter;
  logic clk = 0, rst = 1, clear = 0, load = 0, en = 0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic zf_a, zf_b, zf_c, bz_a, bz_b, bz_c;
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
  logic uf_a, uf_b, uf_c;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  flex_down_counter #(.NUM_CNT_BITS(4), .DECREMENT(1), .AUTO_RELOAD(0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .count_enable(en),
    .count_out(cnt_a), .zero_flag(zf_a), .busy(bz_a)
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    , .underflow_err(uf_a)
`endif
  );
  flex_down_counter #(.NUM_CNT_BITS(4), .DECREMENT(1), .AUTO_RELOAD(1)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .count_enable(en),
    .count_out(cnt_b), .zero_flag(zf_b), .busy(bz_b)
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    , .underflow_err(uf_b)
`endif
  );
  flex_down_counter #(.NUM_CNT_BITS(4), .DECREMENT(3), .AUTO_RELOAD(0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val), .count_enable(en),
    .count_out(cnt_c), .zero_flag(zf_c), .busy(bz_c)
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    , .underflow_err(uf_c)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_clear;
    clear = 1; load = 0; en = 0;
    tick;
    clear = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) tick;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== 6'd0) begin n_fail++; $display("FAIL reset_a got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_a, zf_a, bz_a); end
    n_chk++; if ({cnt_b, zf_b, bz_b} !== 6'd0) begin n_fail++; $display("FAIL reset_b got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_b, zf_b, bz_b); end
    n_chk++; if ({cnt_c, zf_c, bz_c} !== 6'd0) begin n_fail++; $display("FAIL reset_c got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_c, zf_c, bz_c); end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    n_chk++; if (uf_c !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %b exp 0", uf_c); end
`endif
    rst = 0;
  endtask
  task automatic test_count_down;
    logic [3:0] ec [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    logic ez [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_clear;
    load = 1; load_val = 4'd3; en = 1;
    tick;
    load = 0;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd3, 1'b0, 1'b1}) begin n_fail++; $display("FAIL cd_load got cnt=%0d zf=%b busy=%b exp 3 0 1", cnt_a, zf_a, bz_a); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++; if ({cnt_a, zf_a, bz_a} !== {ec[i], ez[i], eb[i]}) begin n_fail++; $display("FAIL cd_edge%0d got cnt=%0d zf=%b busy=%b exp %0d %b %b", i + 1, cnt_a, zf_a, bz_a, ec[i], ez[i], eb[i]); end
    end
    en = 0;
  endtask
  task automatic test_auto_reload;
    logic [3:0] ec [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    logic ez [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_clear;
    load = 1; load_val = 4'd2;
    tick;
    load = 0; en = 1;
    n_chk++; if ({cnt_b, zf_b, bz_b} !== {4'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ar_load got cnt=%0d zf=%b busy=%b exp 2 0 1", cnt_b, zf_b, bz_b); end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_chk++; if ({cnt_b, zf_b, bz_b} !== {ec[i], ez[i], 1'b1}) begin n_fail++; $display("FAIL ar_edge%0d got cnt=%0d zf=%b busy=%b exp %0d %b 1", i + 1, cnt_b, zf_b, bz_b, ec[i], ez[i]); end
    end
    en = 0;
    tick;
    n_chk++; if ({cnt_b, zf_b} !== {4'd2, 1'b0}) begin n_fail++; $display("FAIL ar_idle_en got cnt=%0d zf=%b exp 2 0", cnt_b, zf_b); end
  endtask
  task automatic test_back_to_back;
    do_clear;
    load = 1; load_val = 4'd1;
    tick;
    load = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if ({cnt_b, zf_b, bz_b} !== {4'd1, 1'b1, 1'b1}) begin n_fail++; $display("FAIL b2b_edge%0d got cnt=%0d zf=%b busy=%b exp 1 1 1", i + 1, cnt_b, zf_b, bz_b); end
    end
    en = 0;
  endtask
  task automatic test_underflow;
    logic [3:0] ec [3] = '{4'd4, 4'd1, 4'd0};
    do_clear;
    load = 1; load_val = 4'd7;
    tick;
    load = 0; en = 1;
    n_chk++; if (cnt_c !== 4'd7) begin n_fail++; $display("FAIL uf_load got cnt=%0d exp 7", cnt_c); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if (cnt_c !== ec[i]) begin n_fail++; $display("FAIL uf_edge%0d got cnt=%0d exp %0d", i + 1, cnt_c, ec[i]); end
    end
    n_chk++; if ({zf_c, bz_c} !== 2'b10) begin n_fail++; $display("FAIL uf_term got zf=%b busy=%b exp 1 0", zf_c, bz_c); end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    n_chk++; if (uf_c !== 1'b1) begin n_fail++; $display("FAIL uf_set got %b exp 1", uf_c); end
`endif
    do_clear;
    n_chk++; if ({cnt_c, zf_c, bz_c} !== 6'd0) begin n_fail++; $display("FAIL uf_clear got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_c, zf_c, bz_c); end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    n_chk++; if (uf_c !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b exp 1", uf_c); end
`endif
    rst = 1;
    tick;
    rst = 0;
    load = 1; load_val = 4'd6;
    tick;
    load = 0; en = 1;
    tick;
    n_chk++; if (cnt_c !== 4'd3) begin n_fail++; $display("FAIL ex_edge1 got cnt=%0d exp 3", cnt_c); end
    tick;
    n_chk++; if ({cnt_c, zf_c, bz_c} !== {4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ex_term got cnt=%0d zf=%b busy=%b exp 0 1 0", cnt_c, zf_c, bz_c); end
`ifdef FLEX_DOWN_COUNTER_UNDERFLOW_EN
    n_chk++; if (uf_c !== 1'b0) begin n_fail++; $display("FAIL ex_uf got %b exp 0", uf_c); end
`endif
    en = 0;
  endtask
  task automatic test_priority;
    do_clear;
    load = 1; load_val = 4'd2;
    tick;
    load = 0; en = 1;
    tick;
    n_chk++; if (cnt_a !== 4'd1) begin n_fail++; $display("FAIL pr_setup got cnt=%0d exp 1", cnt_a); end
    clear = 1; load = 1; load_val = 4'd9; en = 1;
    tick;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== 6'd0) begin n_fail++; $display("FAIL pr_clear got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_a, zf_a, bz_a); end
    clear = 0;
    tick;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd9, 1'b0, 1'b1}) begin n_fail++; $display("FAIL pr_load got cnt=%0d zf=%b busy=%b exp 9 0 1", cnt_a, zf_a, bz_a); end
    load = 0; en = 0;
  endtask
  task automatic test_load_zero;
    do_clear;
    load = 1; load_val = 4'd0;
    tick;
    load = 0; en = 1;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lz_expired got cnt=%0d zf=%b busy=%b exp 0 1 0", cnt_a, zf_a, bz_a); end
    tick;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lz_hold got cnt=%0d zf=%b busy=%b exp 0 1 0", cnt_a, zf_a, bz_a); end
    load = 1; load_val = 4'd2;
    tick;
    load = 0;
    tick;
    n_chk++; if ({cnt_a, cnt_b} !== {4'd1, 4'd1}) begin n_fail++; $display("FAIL lz_run got a=%0d b=%0d exp 1 1", cnt_a, cnt_b); end
    load = 1; load_val = 4'd5;
    tick;
    load = 0; en = 0;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd5, 1'b0, 1'b1}) begin n_fail++; $display("FAIL lz_reload_a got cnt=%0d zf=%b busy=%b exp 5 0 1", cnt_a, zf_a, bz_a); end
    n_chk++; if ({cnt_b, zf_b, bz_b} !== {4'd5, 1'b0, 1'b1}) begin n_fail++; $display("FAIL lz_reload_b got cnt=%0d zf=%b busy=%b exp 5 0 1", cnt_b, zf_b, bz_b); end
  endtask
  task automatic test_async_reset;
    do_clear;
    load = 1; load_val = 4'd8;
    tick;
    load = 0; en = 1;
    repeat (3) tick;
    en = 0;
    n_chk++; if (cnt_a !== 4'd5) begin n_fail++; $display("FAIL ar_pre got cnt=%0d exp 5", cnt_a); end
    rst = 1;
    #2;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== 6'd0) begin n_fail++; $display("FAIL rst_async got cnt=%0d zf=%b busy=%b exp 0 0 0", cnt_a, zf_a, bz_a); end
    rst = 0; load = 1; load_val = 4'd4;
    tick;
    load = 0;
    n_chk++; if ({cnt_a, zf_a, bz_a} !== {4'd4, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rst_first_load got cnt=%0d zf=%b busy=%b exp 4 0 1", cnt_a, zf_a, bz_a); end
  endtask
  initial begin
    test_reset;
    test_count_down;
    test_auto_reload;
    test_back_to_back;
    test_underflow;
    test_priority;
    test_load_zero;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flex_down_counter.md
# flex_down_counter

Loadable, programmable-step down-counter with terminal-count detection and optional auto-reload. It is the counterpart to the up-counting flex counter: it starts from a loaded value and counts down to zero. It serves as the countdown timer and credit counter in the edge-detector datapath, for example for remaining pixels in a row or remaining rows in a frame. All outputs are registered.

## Interface
Parameters:
- NUM_CNT_BITS, 4, width of count and load value
- DECREMENT, 1, step subtracted per enabled cycle; legal range 1 to 2^NUM_CNT_BITS-1
- AUTO_RELOAD, 0, 1 = reload the stored load value on terminal count and keep running; 0 = stop at zero

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- clear  input  1  synchronous clear, highest priority
- load  input  1  capture load_val and start counting
- load_val  input  NUM_CNT_BITS  start and reload value
- count_enable  input  1  decrement this cycle (ignored unless RUN)
- count_out  output  NUM_CNT_BITS  current count
- zero_flag  output  1  terminal-count indication
- busy  output  1  high while in RUN
- underflow_err  output  1  sticky error; present only with FLEX_DOWN_COUNTER_UNDERFLOW_EN

## Operation
- Reset: state IDLE; count_out, reload register, zero_flag, busy and underflow_err are all 0.
- Input priority per cycle: clear > load > count_enable.
- States:
  - IDLE: counter holds. load with load_val≠0 → RUN, count_out=load_val, reload register=load_val. load with load_val=0 → EXPIRED, zero_flag=1.
  - RUN: on count_enable, if count_out>DECREMENT then count_out−=DECREMENT. If count_out≤DECREMENT this is a terminal event:
    - AUTO_RELOAD=1: count_out=reload register, stay RUN, zero_flag pulses for exactly one cycle.
    - AUTO_RELOAD=0: count_out=0, go to EXPIRED, zero_flag=1.
    - load in RUN restarts the count from load_val with no terminal event and no pulse.
  - EXPIRED: count_out=0, zero_flag held high, busy=0, count_enable ignored. load restarts exactly as from IDLE; clear → IDLE.
- clear in any state: → IDLE, count_out=0, reload register=0, zero_flag=0. underflow_err is not affected.
- Arithmetic is unsigned at NUM_CNT_BITS width with no wrap-around. A subtraction that would go below zero saturates at the terminal event above.
- Simultaneous load and terminal event: load wins and zero_flag stays 0.

## Timing
- Every output changes only on the rising clk edge, except asynchronous assertion of rst.
- Load latency is 1 cycle: load sampled at edge N gives count_out=load_val and busy=1 after edge N.
- Decrement latency is 1 cycle per enabled edge; the count is not updated in cycles where count_enable=0.
- zero_flag rises after the edge that samples the terminal event.
  - In auto-reload mode it falls after the next edge unless a further terminal event occurs.
  - Back-to-back terminal events (reload value ≤ DECREMENT with continuous enable) hold zero_flag high continuously.
- busy falls on the same edge that zero_flag rises (non-reload mode).
- rst asserted mid-count returns every output to its reset value immediately. The first load is accepted on the first edge after rst deasserts.

## Configuration
- FLEX_DOWN_COUNTER_UNDERFLOW_EN defined: adds port underflow_err. It is set on a terminal event where count_out<DECREMENT, meaning the remaining count was not an exact multiple of the step. It stays set until rst; clear does not reset it.
- Macro undefined: the port and its logic are absent. Saturation behaviour is identical otherwise.

## Structure
- Shared package edge_pkg holds:
  - the state enum type fdc_state_t {FDC_IDLE, FDC_RUN, FDC_EXPIRED}, encoded in 2 bits
  - a constant FDC_RESET_STATE = FDC_IDLE
- One natural sub-module, fdc_next_count: combinational next-count, terminal and underflow detection from (count, reload, DECREMENT, AUTO_RELOAD).
- State register, count register, reload register and flag registers live in the top module.

## Test plan
Unless noted, the bench uses NUM_CNT_BITS=4.
- DECREMENT=1, AUTO_RELOAD=0; load 3, continuous enable → count_out 3,2,1,0. zero_flag=1 and busy=0 after the 3rd enabled edge. Further enables keep count_out=0.
- DECREMENT=1, AUTO_RELOAD=1; load 2, continuous enable for 6 edges → count_out 2,1,2,1,2,1,2. zero_flag is a 1-cycle pulse after edges 2, 4 and 6.
- DECREMENT=3, macro defined; load 7, enable → count_out 7,4,1,0. underflow_err=1 after the 3rd edge and survives clear. Repeat with load 6 → underflow_err stays 0.
- Priority: in RUN with count 1, assert load(9), count_enable and clear together → IDLE, count_out=0. Next cycle, load(9) with enable → count_out=9 and zero_flag=0.
- load_val=0 → EXPIRED next edge, zero_flag=1, busy=0. In RUN with count 1, load 5 plus enable → count_out=5 and no zero_flag pulse.
- Assert rst mid-count at count 5 → all outputs 0 asynchronously. After deassertion, load 4 accepted on the first edge.
